// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and timekeeping: debounced buttons, run/stop/idle FSM,
// 10 ms prescaler and a four-digit BCD counter (SS.hh) with lap capture.
`timescale 1ns/1ps

module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV        = 1_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       mclk_i,
    input  logic       rst_i,
    input  logic       btn_start_i,
    input  logic       btn_clear_i,
    input  logic       btn_lap_i,
    output logic [3:0] digit3_o,
    output logic [3:0] digit2_o,
    output logic [3:0] digit1_o,
    output logic [3:0] digit0_o,
    output logic       running_o,
    output logic       lap_held_o,
    output logic       overflow_o
);

    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PscW = $clog2(TICK_DIV);

    localparam int unsigned BtnStart = 0;
    localparam int unsigned BtnClear = 1;
    localparam int unsigned BtnLap   = 2;

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    logic [2:0]           btn_raw;
    logic [2:0]           sync1_q, sync2_q;
    logic [2:0][DbW-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]           deb_q, deb_d;
    logic [2:0]           deb_dly_q;
    logic [2:0]           press_q;

    state_e               state_q, state_d;
    logic                 start_press, clear_press, lap_press;
    logic                 clr_all, lap_set, lap_clr;

    logic [PscW-1:0]      psc_q, psc_d;
    logic                 tick;
    logic [3:0][3:0]      cnt_q, cnt_d;
    logic                 carry;
    logic                 ovf_q, ovf_d;
    logic [3:0][3:0]      lap_q, lap_d;
    logic                 lap_held_q, lap_held_d;
    logic [3:0][3:0]      disp_q, disp_d;
    logic                 running_q, running_d;

    assign btn_raw = {btn_lap_i, btn_clear_i, btn_start_i};

    // Two-flop synchronizers for the asynchronous button inputs
    always_ff @(posedge mclk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive cycles where the synchronized level disagrees
    always_comb begin
        db_cnt_d = db_cnt_q;
        deb_d    = deb_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_d[i] = '0;
                deb_d[i]    = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
        end
    end

    // Debounced levels and registered one-cycle press pulses on rising edges
    always_ff @(posedge mclk_i or posedge rst_i) begin
        if (rst_i) begin
            db_cnt_q  <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            press_q   <= deb_q & ~deb_dly_q;
        end
    end

    // Start wins over clear/lap pulses arriving in the same cycle
    assign start_press = press_q[BtnStart];
    assign clear_press = press_q[BtnClear] & ~start_press;
    assign lap_press   = press_q[BtnLap] & ~start_press;

    // FSM next state and control strobes for the datapath
    always_comb begin
        state_d = state_q;
        clr_all = 1'b0;
        lap_set = 1'b0;
        lap_clr = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_press) begin
                    state_d = StRun;
                end else if (clear_press) begin
                    clr_all = 1'b1;
                end
            end
            StRun: begin
                if (start_press) begin
                    state_d = StStop;
                end else if (lap_press) begin
                    if (lap_held_q) begin
                        lap_clr = 1'b1;
                    end else begin
                        lap_set = 1'b1;
                    end
                end
            end
            StStop: begin
                if (start_press) begin
                    state_d = StRun;
                end else if (clear_press) begin
                    state_d = StIdle;
                    clr_all = 1'b1;
                end else if (lap_press) begin
                    lap_clr = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Prescaler, BCD counter with carry chain, lap capture and display select
    always_comb begin
        tick       = (state_q == StRun) && (psc_q == PscW'(TICK_DIV - 1));
        psc_d      = psc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        lap_d      = lap_q;
        lap_held_d = lap_held_q;
        carry      = 1'b0;

        if (clr_all) begin
            psc_d = '0;
        end else if (state_q == StRun) begin
            psc_d = tick ? '0 : psc_q + PscW'(1);
        end

        if (clr_all) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (tick) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (cnt_q[i] >= 4'd9) begin
                        cnt_d[i] = 4'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                        carry    = 1'b0;
                    end
                end
            end
            // Carry out of the tens-of-seconds digit means 99.99 wrapped to 00.00
            if (carry) begin
                ovf_d = 1'b1;
            end
        end

        if (clr_all || lap_clr) begin
            lap_held_d = 1'b0;
        end else if (lap_set) begin
            lap_d      = cnt_q;
            lap_held_d = 1'b1;
        end

        disp_d    = lap_held_d ? lap_d : cnt_d;
        running_d = (state_d == StRun);
    end

    // State and datapath registers; outputs come straight from flops
    always_ff @(posedge mclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            psc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            lap_q      <= '0;
            lap_held_q <= 1'b0;
            disp_q     <= '0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            psc_q      <= psc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            lap_q      <= lap_d;
            lap_held_q <= lap_held_d;
            disp_q     <= disp_d;
            running_q  <= running_d;
        end
    end

    assign digit3_o   = disp_q[3];
    assign digit2_o   = disp_q[2];
    assign digit1_o   = disp_q[1];
    assign digit0_o   = disp_q[0];
    assign running_o  = running_q;
    assign lap_held_o = lap_held_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic,
// checked every cycle against an event-level model of elapsed run time.
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

    localparam int TD     = 4;
    localparam int DB     = 3;
    // Raw rise before edge n+1 -> press pulse after edge n+DB+3 -> state at n+DB+4
    localparam int EV_LAT = DB + 4;

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MStop = 2;

    logic       mclk = 1'b0;
    logic       rst  = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap   = 1'b0;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic       running, lap_held, overflow;
    logic [15:0] dut_dig;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model: elapsed time is simply (edges spent in RUN) / TD
    int m_state = MIdle;
    int m_run_edges = 0;
    int m_lap = 0;
    bit m_lap_held = 1'b0;
    bit ev_s [int];
    bit ev_c [int];
    bit ev_l [int];

    stopwatch_ctrl #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DB)
    ) u_dut (
        .mclk_i      (mclk),
        .rst_i       (rst),
        .btn_start_i (btn_start),
        .btn_clear_i (btn_clear),
        .btn_lap_i   (btn_lap),
        .digit3_o    (digit3),
        .digit2_o    (digit2),
        .digit1_o    (digit1),
        .digit0_o    (digit0),
        .running_o   (running),
        .lap_held_o  (lap_held),
        .overflow_o  (overflow)
    );

    assign dut_dig = {digit3, digit2, digit1, digit0};

    always #5 mclk = ~mclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int m_total();
        return m_run_edges / TD;
    endfunction

    function automatic int m_disp();
        return m_lap_held ? m_lap : m_total() % 10000;
    endfunction

    task automatic m_reset();
        m_state     = MIdle;
        m_run_edges = 0;
        m_lap       = 0;
        m_lap_held  = 1'b0;
        ev_s.delete();
        ev_c.delete();
        ev_l.delete();
    endtask

    task automatic m_step(input int k);
        bit s, c, l;
        int pre;
        s   = ev_s.exists(k);
        c   = ev_c.exists(k);
        l   = ev_l.exists(k);
        pre = m_total() % 10000;
        if (m_state == MRun) m_run_edges++;
        if (s) begin
            m_state = (m_state == MRun) ? MStop : MRun;
        end else if (c && m_state != MRun) begin
            m_state     = MIdle;
            m_run_edges = 0;
            m_lap_held  = 1'b0;
        end else if (l) begin
            if (m_state == MRun) begin
                if (m_lap_held) begin
                    m_lap_held = 1'b0;
                end else begin
                    m_lap      = pre;
                    m_lap_held = 1'b1;
                end
            end else if (m_state == MStop) begin
                m_lap_held = 1'b0;
            end
        end
        ev_s.delete(k);
        ev_c.delete(k);
        ev_l.delete(k);
    endtask

    // Advance the model on every active edge
    always @(posedge mclk) begin
        if (rst) m_reset();
        else m_step(cyc + 1);
        cyc <= cyc + 1;
    end

    // Continuous comparison against the model, away from the active edge
    always @(negedge mclk) begin
        if (chk_en) begin
            check_eq("mdl_digits", dut_dig, to_bcd(m_disp()));
            check_eq("mdl_running", running, m_state == MRun);
            check_eq("mdl_lap_held", lap_held, m_lap_held);
            check_eq("mdl_overflow", overflow, m_total() >= 10000);
        end
    end

    // Clean press: must be called at a negedge; schedules the model event
    task automatic press(input bit s, input bit c, input bit l, output int ev_edge);
        ev_edge = cyc + EV_LAT;
        if (s) ev_s[ev_edge] = 1'b1;
        if (c) ev_c[ev_edge] = 1'b1;
        if (l) ev_l[ev_edge] = 1'b1;
        btn_start = s;
        btn_clear = c;
        btn_lap   = l;
        repeat (10) @(negedge mclk);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        repeat (10) @(negedge mclk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge mclk);
    endtask

    task automatic wait_total(input string tag, input int t, input int budget);
        int n;
        n = 0;
        while (m_total() < t && n < budget) begin
            @(negedge mclk);
            n++;
        end
        check_eq(tag, dut_dig, to_bcd(t % 10000));
    endtask

    initial begin
        int e, e2, e3, ev;
        logic [2:0] r;

        @(negedge mclk);
        @(negedge mclk);
        check_eq("rst_digits", dut_dig, 16'h0000);
        check_eq("rst_running", running, 1'b0);
        check_eq("rst_lap_held", lap_held, 1'b0);
        check_eq("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge mclk);

        // Start, run 40 edges, stop and confirm the count holds
        press(1'b1, 1'b0, 1'b0, e);
        wait_until(e + 40);
        check_eq("run40_digits", dut_dig, 16'h0010);
        check_eq("run40_running", running, 1'b1);
        press(1'b1, 1'b0, 1'b0, e2);
        wait_until(e2 + 35);
        check_eq("stop_running", running, 1'b0);
        check_eq("stop_hold", dut_dig, to_bcd((e2 - e) / TD));

        // Lap capture at 00.05, release at live 00.12
        press(1'b0, 1'b1, 1'b0, ev);
        check_eq("clr_digits", dut_dig, 16'h0000);
        press(1'b1, 1'b0, 1'b0, e3);
        wait_until(e3 + 15);
        press(1'b0, 1'b0, 1'b1, ev);
        check_eq("lap_held_set", lap_held, 1'b1);
        check_eq("lap_frozen", dut_dig, 16'h0005);
        wait_until(e3 + 43);
        press(1'b0, 1'b0, 1'b1, ev);
        check_eq("lap_released", lap_held, 1'b0);
        check_eq("lap_live", dut_dig, 16'h0015);

        // Start+clear together in STOP resumes; clear in RUN is ignored
        press(1'b1, 1'b0, 1'b0, ev);
        press(1'b1, 1'b1, 1'b0, ev);
        check_eq("simul_running", running, 1'b1);
        check_eq("simul_kept", dut_dig, to_bcd(m_total()));
        press(0, 1'b1, 1'b0, ev);
        check_eq("clr_in_run", running, 1'b1);
        check_eq("clr_in_run_dig", dut_dig, to_bcd(m_total()));

        // Random button traffic, including coincident presses
        for (int i = 0; i < 40; i++) begin
            r = 3'($urandom_range(0, 7));
            press(r[0], r[1], r[2], ev);
            repeat ($urandom_range(0, 25)) @(negedge mclk);
        end

        // Back to IDLE, then a bouncing start button
        if (m_state == MRun) press(1'b1, 1'b0, 1'b0, ev);
        press(1'b0, 1'b1, 1'b0, ev);
        check_eq("idle_running", running, 1'b0);
        check_eq("idle_digits", dut_dig, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            btn_start = 1'b1;
            repeat (2) @(negedge mclk);
            btn_start = 1'b0;
            repeat (2) @(negedge mclk);
        end
        repeat (4) @(negedge mclk);
        check_eq("bounce_quiet", running, 1'b0);
        press(1'b1, 1'b0, 1'b0, ev);
        check_eq("bounce_one", running, 1'b1);

        // Run through 99.99 and check the wrap
        wait_total("near_max", 9998, 45000);
        check_eq("near_max_ovf", overflow, 1'b0);
        wait_total("wrap_zero", 10000, 20);
        check_eq("wrap_ovf", overflow, 1'b1);
        wait_total("wrap_one", 10001, 20);
        check_eq("wrap_ovf_sticky", overflow, 1'b1);
        press(1'b1, 1'b0, 1'b0, ev);
        press(1'b0, 1'b1, 1'b0, ev);
        check_eq("clr_ovf", overflow, 1'b0);
        check_eq("clr_ovf_digits", dut_dig, 16'h0000);
        check_eq("clr_ovf_running", running, 1'b0);

        // Asynchronous reset mid-run at 00.37
        press(1'b1, 1'b0, 1'b0, ev);
        wait_total("pre_rst", 37, 400);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("arst_digits", dut_dig, 16'h0000);
        check_eq("arst_running", running, 1'b0);
        check_eq("arst_lap_held", lap_held, 1'b0);
        check_eq("arst_overflow", overflow, 1'b0);
        repeat (2) @(negedge mclk);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (10) @(negedge mclk);
        check_eq("post_rst_running", running, 1'b0);
        check_eq("post_rst_digits", dut_dig, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and timekeeping stage of the Boolean Board stopwatch: debounces the start/stop, clear and lap pushbuttons, runs an FSM and a 4-digit BCD time counter (SS.hh, 00.00–99.99), and presents four registered BCD digits. The block feeds the seven-segment multiplexer/encoder stage directly; that stage only encodes and scans the digits and never counts.

## Interface
- TICK_DIV, 1_000_000: mclk cycles per 10 ms hundredths tick (100 MHz mclk); legal ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized cycles required to accept a button level change; legal ≥ 1.

- mclk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_start  in  1  raw start/stop button, active high, asynchronous to mclk.
- btn_clear  in  1  raw clear button, active high.
- btn_lap  in  1  raw lap button, active high.
- digit3  out  4  BCD seconds tens (leftmost).
- digit2  out  4  BCD seconds units.
- digit1  out  4  BCD tenths.
- digit0  out  4  BCD hundredths (rightmost).
- running  out  1  high in RUN state.
- lap_held  out  1  high while display is frozen on a lap capture.
- overflow  out  1  sticky; set on wrap 99.99→00.00.

## Operation
- Per button: 2-FF synchronizer → debounce counter (resets whenever synchronized level equals debounced level; debounced level flips when counter reaches DEBOUNCE_CYCLES) → rising-edge detector giving a 1-cycle press pulse. Releases produce no event.
- FSM states: IDLE (count 00.00, stopped), RUN, STOP.
  - start press: IDLE→RUN, RUN→STOP, STOP→RUN.
  - clear press: STOP or IDLE→IDLE; count zeroed, overflow cleared, lap_held cleared, prescaler zeroed. Ignored in RUN.
  - lap press: RUN: if !lap_held, latch live count into lap register and set lap_held; if lap_held, clear lap_held. STOP: clears lap_held if set, otherwise ignored. IDLE: ignored.
  - Same-cycle presses: start has priority; clear/lap pulses in that cycle are discarded.
- Prescaler: counts 0..TICK_DIV-1 only in RUN; tick pulse when at TICK_DIV-1 (then wraps to 0). Frozen (not cleared) in STOP so fractional time is preserved on resume; cleared on IDLE entry.
- BCD counter increments once per tick: digit0 9→0 carries to digit1, digit1 9→0 to digit2, digit2 9→0 to digit3, digit3 9→0 wraps all to 00.00, sets overflow, counting continues. Digits are never outside 0–9.
- Counter keeps running while lap_held; outputs digit3..0 show lap register when lap_held, live count otherwise.

## Timing
- Reset (async assert, sync use after deassert): state IDLE; digit3..0 = 0; running = 0; lap_held = 0; overflow = 0; prescaler, debounce counters, synchronizers, debounced levels = 0. Button held through reset deassertion yields a press after debounce.
- Raw button rising edge held stable → press pulse DEBOUNCE_CYCLES+3 cycles later; FSM state, running, lap_held update on the next edge. Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- In RUN, first tick occurs TICK_DIV cycles after RUN entry from IDLE; digits update the edge after the tick.
- Tick coincident with start press in RUN: increment applied, state becomes STOP same edge.
- All outputs registered; no combinational path from buttons to outputs.

## Test plan
- TICK_DIV=4, DEBOUNCE_CYCLES=3: reset, press start, run 40 cycles → running=1, digits 00.10; press start → running=0, digits hold at value for 30+ cycles.
- Preload near max (run to 99.98), 2 more ticks → digits 00.00 then 00.01, overflow=1; stop, clear → 00.00, overflow=0, state IDLE.
- Bounce: btn_start toggled every 2 cycles for 20 cycles then held high → exactly one start event, running=1.
- Lap: in RUN at 00.05 press lap → lap_held=1, digits frozen at 00.05 while live continues; press lap at live 00.12 → lap_held=0, digits show ≥00.12.
- Simultaneous start+clear pulses in STOP → RUN entered, count not cleared; clear pressed in RUN → ignored.
- Assert rst mid-RUN at 00.37 → all outputs 0 immediately (asynchronously), IDLE after deassert.
